div: RTL and testbench

Multi-cycle 32-bit signed/unsigned divider for DIV/DIVU in the EX stage. It accepts operands from EX and runs one restoring-division step per cycle. It returns {remainder, quotient} for the HI/LO write path. It drives `stallreq_from_ex` into the pipeline control unit, holding IF..EX (stall pattern 9'b000011111) until the result is ready.

---
 rtl/div_pkg.sv | 18 +
 rtl/div.sv | 113 +++++++++++
 tb/tb_div.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle DIV/DIVU unit: FSM encoding and handshake levels.
package div_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div.sv
// Restoring divider for DIV/DIVU: one quotient bit per cycle, {remainder, quotient} on a
// one-cycle ready pulse, stall request held to the pipeline until that pulse.
module div
    import div_pkg::*;
#(
    parameter int unsigned DW = DivWidth
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            signed_div_i,
    input  logic [DW-1:0]   opdata1_i,
    input  logic [DW-1:0]   opdata2_i,
    input  logic            annul_i,
    output logic [2*DW-1:0] result_o,
    output logic            ready_o,
    output logic            stallreq_o
);

    localparam int unsigned CntW = $clog2(DW + 1);

    div_state_e      state;
    logic [CntW-1:0] cnt;
    logic [2*DW:0]   shreg;
    logic [DW-1:0]   divisor;
    logic            neg_quo;
    logic            neg_rem;

    logic [DW-1:0]   abs1;
    logic [DW-1:0]   abs2;
    logic            ge;
    logic [DW:0]     diff;
    logic [2*DW:0]   shreg_next;
    logic [DW-1:0]   quo_raw;
    logic [DW-1:0]   rem_raw;

    always_comb begin
        abs1 = (signed_div_i && opdata1_i[DW-1]) ? -opdata1_i : opdata1_i;
        abs2 = (signed_div_i && opdata2_i[DW-1]) ? -opdata2_i : opdata2_i;

        // Compare the post-shift upper DW+1 bits; the top register bit is folded in so a
        // (never expected) carry out of the shift still counts as "greater".
        ge   = shreg[2*DW:DW-1] >= {2'b00, divisor};
        diff = shreg[2*DW-1:DW-1] - {1'b0, divisor};

        shreg_next = ge ? {diff, shreg[DW-2:0], 1'b1} : {shreg[2*DW-1:0], 1'b0};
        quo_raw    = shreg_next[DW-1:0];
        rem_raw    = shreg_next[2*DW-1:DW];
    end

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            shreg    <= '0;
            divisor  <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            unique case (state)
                DivFree: begin
                    ready_o <= DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            shreg   <= {{(DW + 1){1'b0}}, abs1};
                            divisor <= abs2;
                            neg_quo <= signed_div_i & (opdata1_i[DW-1] ^ opdata2_i[DW-1]);
                            neg_rem <= signed_div_i & opdata1_i[DW-1];
                            cnt     <= '0;
                            state   <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        // Architecturally unpredictable; zero keeps the result deterministic.
                        result_o <= '0;
                        ready_o  <= DivResultReady;
                        state    <= DivEnd;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                    end else begin
                        shreg <= shreg_next;
                        cnt   <= cnt + CntW'(1);
                        if (cnt == CntW'(DW - 1)) begin
                            result_o <= {neg_rem ? -rem_raw : rem_raw,
                                         neg_quo ? -quo_raw : quo_raw};
                            ready_o  <= DivResultReady;
                            state    <= DivEnd;
                        end
                    end
                end
                DivEnd: begin
                    ready_o <= DivResultNotReady;
                    state   <= DivFree;
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed timing scenarios plus random operands against an
// arithmetic reference model.
module tb_div;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int total;
    int bad;

    div #(.DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 64-bit arithmetic, truncating division, remainder follows dividend sign.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one divide at the next cycle T and checks stall, latency and result.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic keep, input string name);
        int n;
        int exp_lat;
        logic done;
        logic [63:0] exp;
        @(negedge clk);
        total++;
        if (ready_o !== 1'b0) begin
            bad++;
            $display("FAIL %s ready_pulse_width: ready=%b required 0", name, ready_o);
        end
        start_i      = 1'b1;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        #1;
        total++;
        if (stallreq_o !== 1'b1) begin
            bad++;
            $display("FAIL %s stall_at_accept: stall=%b required 1", name, stallreq_o);
        end
        exp_lat = (b == 32'd0) ? 2 : 33;
        exp     = model(a, b, s);
        n       = 0;
        done    = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (ready_o === 1'b1) begin
                done = 1'b1;
            end else begin
                total++;
                if (stallreq_o !== 1'b1) begin
                    bad++;
                    $display("FAIL %s stall_busy: cycle T+%0d stall=%b required 1",
                             name, n, stallreq_o);
                end
            end
        end
        total++;
        if (!done || n != exp_lat) begin
            bad++;
            $display("FAIL %s latency: got %0d (done=%b) required %0d", name, n, done, exp_lat);
        end
        total++;
        if (result_o !== exp) begin
            bad++;
            $display("FAIL %s result: got %h required %h (a=%h b=%h s=%b)",
                     name, result_o, exp, a, b, s);
        end
        total++;
        if (stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL %s stall_at_ready: stall=%b required 0", name, stallreq_o);
        end
        if (!keep) start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        annul_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0 || stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ready=%b result=%h stall=%b required 0/0/0",
                     ready_o, result_o, stallreq_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        run_div(32'd7, 32'd2, 1'b0, 1'b0, "udiv_7_2");
        total++;
        if (result_o !== {32'h1, 32'h3}) begin
            bad++;
            $display("FAIL udiv_7_2_const: got %h required %h", result_o, {32'h1, 32'h3});
        end
        run_div(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, "sdiv_m7_2");
        total++;
        if (result_o !== {32'hFFFFFFFF, 32'hFFFFFFFD}) begin
            bad++;
            $display("FAIL sdiv_m7_2_const: got %h required FFFFFFFFFFFFFFFD", result_o);
        end
        run_div(32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "udiv_fff9_2");
        total++;
        if (result_o !== {32'h1, 32'h7FFFFFFC}) begin
            bad++;
            $display("FAIL udiv_fff9_2_const: got %h required 000000017FFFFFFC", result_o);
        end
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, "sdiv_overflow");
        total++;
        if (result_o !== {32'h0, 32'h80000000}) begin
            bad++;
            $display("FAIL sdiv_overflow_const: got %h required 0000000080000000", result_o);
        end
        run_div(32'h12345678, 32'd0, 1'b0, 1'b0, "div_by_zero");
        run_div(32'h87654321, 32'd0, 1'b1, 1'b0, "sdiv_by_zero");
    endtask

    task automatic test_annul();
        logic seen;
        int n;
        @(negedge clk);
        start_i = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        seen = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen = 1'b1;
        end
        annul_i = 1'b1;
        #1;
        total++;
        if (stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_stall: stall=%b required 0", stallreq_o);
        end
        @(negedge clk);
        annul_i = 1'b0;
        opdata1_i = 32'd500;
        opdata2_i = 32'd7;
        n = 11;
        while (ready_o !== 1'b1 && n < 120) begin
            @(negedge clk);
            n++;
            if (n == 12 && ready_o === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL annul_no_ready: spurious ready seen=%b required 0", seen);
        end
        total++;
        if (n != 44) begin
            bad++;
            $display("FAIL annul_restart_latency: ready at T+%0d required T+44", n);
        end
        total++;
        if (result_o !== model(32'd500, 32'd7, 1'b0)) begin
            bad++;
            $display("FAIL annul_restart_result: got %h required %h",
                     result_o, model(32'd500, 32'd7, 1'b0));
        end
        start_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_div(32'd100, 32'd7, 1'b0, 1'b1, "b2b_first");
        total++;
        if (result_o !== {32'd2, 32'd14}) begin
            bad++;
            $display("FAIL b2b_first_const: got %h required %h", result_o, {32'd2, 32'd14});
        end
        run_div(32'hFFFFFFFF, 32'h10, 1'b0, 1'b0, "b2b_second");
        total++;
        if (result_o !== {32'hF, 32'h0FFFFFFF}) begin
            bad++;
            $display("FAIL b2b_second_const: got %h required 0000000F0FFFFFFF", result_o);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        start_i = 1'b1;
        signed_div_i = 1'b1;
        opdata1_i = 32'hDEADBEEF;
        opdata2_i = 32'd13;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_i = 1'b0;
        total++;
        if (seen || ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++;
            $display("FAIL reset_mid: seen=%b ready=%b result=%h required 0/0/0",
                     seen, ready_o, result_o);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_o === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_mid_no_ready: ready pulse seen=%b required 0", seen);
        end
        run_div(32'hDEADBEEF, 32'd13, 1'b1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: a = 32'h80000000;
                4: b = a;
                default: ;
            endcase
            run_div(a, b, s, 1'($urandom_range(0, 1)), "random");
        end
        start_i = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_annul();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
